// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_W_IN          = 16;
    localparam int DEF_BITS_PER_WORD = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when req is all zero.
// Ports: req (request mask), last (previous winner), any (some request set), idx (winner index).
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Walk offsets from farthest to nearest so the nearest candidate after
    // 'last' is the one left standing when the loop ends.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                any = 1'b1;
                idx = IW'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX engine among NUM_REQ stream requesters, round-robin per word,
// Latency: word accepted in IDLE, first character valid 1 cycle later, one IDLE cycle between words.
// Backpressure: tx_ready low holds the current character; s_ready stays low for the whole word.
// Ports: cfg_en/s_valid/s_data/s_ready = requester side; tx_valid/tx_data/tx_ready = UART side;
//        grant_id = current owner; busy = word in flight.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int W_IN          = DEF_W_IN,
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 cfg_en,
    input  logic [NUM_REQ-1:0]                 s_valid,
    input  logic [NUM_REQ-1:0][W_IN-1:0]       s_data,
    output logic [NUM_REQ-1:0]                 s_ready,
    output logic                               tx_valid,
    output logic [BITS_PER_WORD-1:0]           tx_data,
    input  logic                               tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int NUM_CHARS = W_IN / BITS_PER_WORD;
    localparam int IW        = $clog2(NUM_REQ);
    localparam int CW        = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_grant;
    logic [W_IN-1:0] shreg;
    logic [CW-1:0]   cnt;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_any;
    logic [IW-1:0]      pick_idx;
    logic               take;
    logic               tx_fire;
    logic               last_char;

    assign eligible  = s_valid & cfg_en;
    assign tx_fire   = tx_valid & tx_ready;
    assign last_char = (cnt == CW'(NUM_CHARS - 1));
    assign tx_data   = shreg[BITS_PER_WORD-1:0];
    assign busy      = (state == SEND);

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req  (eligible),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // s_ready is masked during reset so no word can be accepted on a reset edge.
    always_comb begin
        state_nxt = state;
        s_ready   = '0;
        take      = 1'b0;
        tx_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !rst) begin
                    s_ready   = NUM_REQ'(1) << pick_idx;
                    take      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && last_char) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 wins the first search.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            grant_id   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else if (take) begin
            shreg      <= s_data[pick_idx];
            cnt        <= '0;
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
        end else if (tx_fire) begin
            shreg <= shreg >> BITS_PER_WORD;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with default sizing (4 requesters, 16-bit words, 8-bit chars).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cfg_en;
    logic [3:0]        s_valid;
    logic [3:0][15:0]  s_data;
    logic [3:0]        s_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [1:0]        grant_id;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int         exp_grant[$];
    logic [7:0] exp_chars[$];
    bit         mon_en = 1'b0;

    logic [15:0] wd [4] = '{16'hA1A0, 16'hB1B0, 16'hC1C0, 16'hD1D0};

    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs[7];

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .W_IN          (16),
        .BITS_PER_WORD (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_valid  = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input int g, input logic [15:0] w);
        exp_grant.push_back(g);
        exp_chars.push_back(w[7:0]);
        exp_chars.push_back(w[15:8]);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (exp_chars.size() != 0 || exp_grant.size() != 0); k++) tick();
        check("drain_chars", 32'(exp_chars.size()), 32'd0);
        check("drain_grants", 32'(exp_grant.size()), 32'd0);
    endtask

    // Scoreboard: grants and characters are compared in the order the test queued them.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (s_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_grant: got s_ready %b, expected no grant", s_ready);
                end else begin
                    check("sb_grant", 32'(s_ready), 32'(1) << exp_grant.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_chars.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_char: got tx_data %h, expected no character", tx_data);
                end else begin
                    check("sb_char", 32'(tx_data), 32'(exp_chars.pop_front()));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        cfg_en   = 4'b1111;
        s_valid  = '0;
        s_data   = '0;
        tx_ready = 1'b0;

        // Reset state, with requests pending to show s_ready stays low.
        s_valid = 4'b1111;
        tick();
        tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        rst     = 1'b0;
        s_valid = '0;

        // Table: first pick after reset (requester 0 has priority).
        vecs[0] = '{4'b1111, 4'b0100, 4'b0100};
        vecs[1] = '{4'b1111, 4'b1010, 4'b0010};
        vecs[2] = '{4'b1110, 4'b1111, 4'b0010};
        vecs[3] = '{4'b0000, 4'b1111, 4'b0000};
        vecs[4] = '{4'b1000, 4'b1000, 4'b1000};
        vecs[5] = '{4'b0100, 4'b0110, 4'b0100};
        vecs[6] = '{4'b1111, 4'b0000, 4'b0000};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            cfg_en  = vecs[v].en;
            s_valid = vecs[v].valid;
            #1;
            check("tbl_s_ready", 32'(s_ready), 32'(vecs[v].exp_ready));
            tick();
            s_valid = '0;
            check("tbl_busy", 32'(busy), 32'(vecs[v].exp_ready != 4'b0000));
            if (vecs[v].exp_ready != 4'b0000)
                check("tbl_grant_id", 32'(1) << grant_id, 32'(vecs[v].exp_ready));
        end

        // Requester 2 alone sends 16'hBEEF.
        do_reset();
        mon_en    = 1'b1;
        cfg_en    = 4'b1111;
        s_data[2] = 16'hBEEF;
        s_valid   = 4'b0100;
        tx_ready  = 1'b1;
        push_word(2, 16'hBEEF);
        #1;
        check("beef_s_ready", 32'(s_ready), 32'b0100);
        tick();
        s_valid = '0;
        check("beef_busy", 32'(busy), 32'd1);
        check("beef_tx_valid0", 32'(tx_valid), 32'd1);
        check("beef_char0", 32'(tx_data), 32'hEF);
        check("beef_grant_id", 32'(grant_id), 32'd2);
        tick();
        check("beef_char1", 32'(tx_data), 32'hBE);
        tick();
        check("beef_idle_busy", 32'(busy), 32'd0);
        check("beef_idle_tx_valid", 32'(tx_valid), 32'd0);
        drain();

        // All four valid: grants 0,1,2,3,0 every 3 cycles.
        do_reset();
        cfg_en   = 4'b1111;
        for (int i = 0; i < 4; i++) s_data[i] = wd[i];
        s_valid  = 4'b1111;
        tx_ready = 1'b1;
        push_word(0, wd[0]);
        push_word(1, wd[1]);
        push_word(2, wd[2]);
        push_word(3, wd[3]);
        push_word(0, wd[0]);
        #1;
        for (int c = 0; c < 15; c++) begin
            check("rr_s_ready", 32'(s_ready), (c % 3 == 0) ? (32'(1) << ((c / 3) % 4)) : 32'd0);
            tick();
        end
        s_valid = '0;
        drain();

        // Backpressure: tx_ready low for 5 cycles on character 0 of 16'h1234.
        do_reset();
        cfg_en    = 4'b1111;
        s_data[0] = 16'h1234;
        s_valid   = 4'b0001;
        tx_ready  = 1'b0;
        push_word(0, 16'h1234);
        #1;
        tick();
        s_valid = '0;
        for (int k = 0; k < 5; k++) begin
            check("bp_tx_valid", 32'(tx_valid), 32'd1);
            check("bp_char0", 32'(tx_data), 32'h34);
            tick();
        end
        tx_ready = 1'b1;
        #1;
        check("bp_char0_fire", 32'(tx_data), 32'h34);
        tick();
        check("bp_char1", 32'(tx_data), 32'h12);
        drain();

        // cfg_en=1011: requester 2 skipped; cfg_en[0] cleared mid-word still finishes the word.
        do_reset();
        for (int i = 0; i < 4; i++) s_data[i] = wd[i];
        cfg_en   = 4'b1011;
        s_valid  = 4'b1111;
        tx_ready = 1'b1;
        push_word(0, wd[0]);
        push_word(1, wd[1]);
        push_word(3, wd[3]);
        push_word(1, wd[1]);
        push_word(3, wd[3]);
        #1;
        begin
            int gseq[5] = '{0, 1, 3, 1, 3};
            for (int c = 0; c < 15; c++) begin
                check("en_s_ready", 32'(s_ready), (c % 3 == 0) ? (32'(1) << gseq[c / 3]) : 32'd0);
                check("en_busy", 32'(busy), 32'(c % 3 != 0));
                if (c == 1) cfg_en = 4'b1010;
                tick();
            end
        end
        s_valid = '0;
        drain();

        // Reset during character 1 of a word from requester 3.
        do_reset();
        cfg_en    = 4'b1111;
        s_data[3] = 16'h5A3C;
        s_valid   = 4'b1000;
        tx_ready  = 1'b1;
        exp_grant.push_back(3);
        exp_chars.push_back(8'h3C);
        #1;
        check("rstmid_s_ready", 32'(s_ready), 32'b1000);
        tick();
        s_valid = '0;
        tick();
        check("rstmid_char1", 32'(tx_data), 32'h5A);
        tx_ready = 1'b0;
        rst      = 1'b1;
        tick();
        check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) s_data[i] = wd[i];
        s_valid = 4'b1111;
        push_word(0, wd[0]);
        #1;
        check("rstmid_regrant", 32'(s_ready), 32'b0001);
        tick();
        s_valid = '0;
        drain();

        // Requester 1 alone, three back-to-back words.
        do_reset();
        cfg_en    = 4'b1111;
        s_data[1] = 16'h1111;
        s_valid   = 4'b0010;
        tx_ready  = 1'b1;
        push_word(1, 16'h1111);
        push_word(1, 16'h2222);
        push_word(1, 16'h3333);
        #1;
        begin
            logic [15:0] nxt[3] = '{16'h2222, 16'h3333, 16'h0000};
            for (int c = 0; c < 9; c++) begin
                check("solo_s_ready", 32'(s_ready), (c % 3 == 0) ? 32'b0010 : 32'd0);
                check("solo_tx_valid", 32'(tx_valid), 32'(c % 3 != 0));
                if (c % 3 == 1) s_data[1] = nxt[c / 3];
                tick();
            end
        end
        s_valid = '0;
        check("solo_gap", 32'(tx_valid), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
